// File: rtl/sparse_block_compressor_pkg.sv
// Shared sparse bitmask format: widths, compressor FSM states and the beat
// payload exchanged with the sparse buffer and the operand matcher.
package sparse_fmt_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned LANES  = 8;
  localparam int unsigned IDX_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2
  } state_e;

  typedef struct packed {
    logic              header;
    logic              last;
    logic [LANES-1:0]  bitmask;
    logic [IDX_W-1:0]  index;
    logic [DATA_W-1:0] data;
  } beat_t;

endpackage

// File: rtl/sparse_block_compressor_if.sv
// Dense block input handshake and sparse beat output handshake of the compressor.
interface sparse_block_compressor_if;
  import sparse_fmt_pkg::*;

  logic                    ivalid;
  logic                    iready;
  logic [LANES*DATA_W-1:0] idata;
  logic                    ovalid;
  logic                    oready;
  logic                    oheader;
  logic [LANES-1:0]        obitmask;
  logic [DATA_W-1:0]       odata;
  logic [IDX_W-1:0]        oindex;
  logic                    olast;

  // Compressor side.
  modport slave (
    input  ivalid, idata, oready,
    output iready, ovalid, oheader, obitmask, odata, oindex, olast
  );

  // Producer / consumer side.
  modport master (
    output ivalid, idata, oready,
    input  iready, ovalid, oheader, obitmask, odata, oindex, olast
  );

endinterface

// File: rtl/sparse_block_compressor_lowest_set_index.sv
// Combinational priority encoder: index of the lowest set bit of a lane mask.
module lowest_set_index #(
  parameter int unsigned LANES = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic [LANES-1:0] i_mask,
  output logic [IDX_W-1:0] o_index_c,
  output logic             o_found_c
);

  // Scan downward so the lowest set bit is written last and wins.
  always_comb begin
    o_index_c = '0;
    o_found_c = 1'b0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (i_mask[i]) begin
        o_index_c = IDX_W'(i);
        o_found_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sparse_block_compressor.sv
// Dense-to-sparse encoder: one header beat with the nonzero bitmask, then one
// beat per nonzero lane in ascending lane order.
module sparse_block_compressor
  import sparse_fmt_pkg::*;
(
  input  logic                       clock,
  input  logic                       reset,
  sparse_block_compressor_if.slave   io_bus
);

  state_e                  r_state;
  logic                    r_ovalid;
  beat_t                   r_beat;
  logic [LANES-1:0]        r_rem;
  logic [LANES*DATA_W-1:0] r_hold;

  state_e                  w_state_nxt;
  logic                    w_ovalid_nxt;
  beat_t                   w_beat_nxt;
  logic [LANES-1:0]        w_rem_nxt;
  logic [LANES*DATA_W-1:0] w_hold_nxt;

  logic                    w_fire;
  logic                    w_done;
  logic                    w_iready;
  logic                    w_accept;
  logic [LANES-1:0]        w_in_mask;
  logic [DATA_W-1:0]       w_lanes [LANES];
  logic [IDX_W-1:0]        w_idx;
  logic                    w_found;
  logic [LANES-1:0]        w_rem_after;

  // r_rem holds lanes not yet presented; the current data beat's lane is already cleared.
  lowest_set_index #(
    .LANES (LANES),
    .IDX_W (IDX_W)
  ) u_lsi (
    .i_mask    (r_rem),
    .o_index_c (w_idx),
    .o_found_c (w_found)
  );

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      w_in_mask[k] = |io_bus.idata[k*DATA_W +: DATA_W];
      w_lanes[k]   = r_hold[k*DATA_W +: DATA_W];
    end
  end

  assign w_rem_after = r_rem & ~(LANES'(1) << w_idx);
  assign w_fire      = r_ovalid & io_bus.oready;
  assign w_done      = w_fire & r_beat.last;
  assign w_iready    = ~reset & ((r_state == ST_IDLE) | w_done);
  assign w_accept    = w_iready & io_bus.ivalid;

  // Next-state and next-beat logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_ovalid_nxt = r_ovalid;
    w_beat_nxt   = r_beat;
    w_rem_nxt    = r_rem;
    w_hold_nxt   = r_hold;

    case (r_state)
      ST_IDLE: begin
        w_ovalid_nxt = 1'b0;
      end
      ST_HEADER, ST_DATA: begin
        if (w_fire && !r_beat.last && w_found) begin
          w_state_nxt        = ST_DATA;
          w_beat_nxt.header  = 1'b0;
          w_beat_nxt.last    = (w_rem_after == '0);
          w_beat_nxt.index   = w_idx;
          w_beat_nxt.data    = w_lanes[w_idx];
          w_rem_nxt          = w_rem_after;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_done) begin
      w_state_nxt  = ST_IDLE;
      w_ovalid_nxt = 1'b0;
      w_beat_nxt   = '0;
      w_rem_nxt    = '0;
    end

    // A done beat and a new block may share a cycle, so load overrides the clear.
    if (w_accept) begin
      w_state_nxt        = ST_HEADER;
      w_ovalid_nxt       = 1'b1;
      w_hold_nxt         = io_bus.idata;
      w_rem_nxt          = w_in_mask;
      w_beat_nxt.header  = 1'b1;
      w_beat_nxt.last    = (w_in_mask == '0);
      w_beat_nxt.bitmask = w_in_mask;
      w_beat_nxt.index   = '0;
      w_beat_nxt.data    = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_ovalid <= 1'b0;
      r_beat   <= '0;
      r_rem    <= '0;
      r_hold   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ovalid <= w_ovalid_nxt;
      r_beat   <= w_beat_nxt;
      r_rem    <= w_rem_nxt;
      r_hold   <= w_hold_nxt;
    end
  end

  assign io_bus.iready   = w_iready;
  assign io_bus.ovalid   = r_ovalid;
  assign io_bus.oheader  = r_beat.header;
  assign io_bus.olast    = r_beat.last;
  assign io_bus.obitmask = r_beat.bitmask;
  assign io_bus.oindex   = r_beat.index;
  assign io_bus.odata    = r_beat.data;

endmodule

// File: tb/tb_sparse_block_compressor.sv
// Directed bench for sparse_block_compressor: beat sequences, stalls, chaining, reset.
module tb_sparse_block_compressor;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  sparse_block_compressor_if bus ();

  sparse_block_compressor dut (
    .clock  (clock),
    .reset  (reset),
    .io_bus (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Samples the presented beat at the falling edge; does not advance past it.
  task automatic beat(input string tag, input logic h, input logic l,
                      input logic [7:0] bm, input logic [2:0] idx, input logic [7:0] d);
    @(negedge clock);
    chk({tag, ".ovalid"},   32'(bus.ovalid),   32'd1);
    chk({tag, ".oheader"},  32'(bus.oheader),  32'(h));
    chk({tag, ".olast"},    32'(bus.olast),    32'(l));
    chk({tag, ".obitmask"}, 32'(bus.obitmask), 32'(bm));
    chk({tag, ".oindex"},   32'(bus.oindex),   32'(idx));
    chk({tag, ".odata"},    32'(bus.odata),    32'(d));
  endtask

  task automatic idle_chk(input string tag);
    @(negedge clock);
    chk({tag, ".ovalid"}, 32'(bus.ovalid), 32'd0);
    chk({tag, ".iready"}, 32'(bus.iready), 32'd1);
    tick();
  endtask

  task automatic send(input string tag, input logic [63:0] blk);
    bus.ivalid = 1'b1;
    bus.idata  = blk;
    @(negedge clock);
    chk({tag, ".iready"}, 32'(bus.iready), 32'd1);
    tick();
    bus.ivalid = 1'b0;
  endtask

  localparam logic [63:0] BLK_S1   = 64'h80_00_00_44_00_00_11_00;
  localparam logic [63:0] BLK_FF   = 64'hFF_FF_FF_FF_FF_FF_FF_FF;
  localparam logic [63:0] BLK_A    = 64'h00_00_00_00_33_00_00_00;
  localparam logic [63:0] BLK_B    = 64'h00_C3_00_00_00_00_00_5A;
  localparam logic [63:0] BLK_R    = 64'h00_00_00_00_00_22_00_00;
  localparam logic [63:0] BLK_JUNK = 64'hDE_AD_BE_EF_01_02_03_04;

  initial begin
    total      = 0;
    bad        = 0;
    reset      = 1'b1;
    bus.ivalid = 1'b0;
    bus.idata  = '0;
    bus.oready = 1'b1;

    // Reset cycle and reset state
    @(negedge clock);
    chk("rst.iready_in_reset", 32'(bus.iready), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("rst.ovalid",   32'(bus.ovalid),   32'd0);
    chk("rst.oheader",  32'(bus.oheader),  32'd0);
    chk("rst.olast",    32'(bus.olast),    32'd0);
    chk("rst.obitmask", 32'(bus.obitmask), 32'd0);
    chk("rst.odata",    32'(bus.odata),    32'd0);
    chk("rst.oindex",   32'(bus.oindex),   32'd0);
    chk("rst.iready",   32'(bus.iready),   32'd1);
    tick();

    // Scenario 1: sparse block, oready held high
    send("s1", BLK_S1);
    beat("s1.hdr", 1'b1, 1'b0, 8'h92, 3'd0, 8'h00);  tick();
    beat("s1.d1",  1'b0, 1'b0, 8'h92, 3'd1, 8'h11);  tick();
    beat("s1.d4",  1'b0, 1'b0, 8'h92, 3'd4, 8'h44);  tick();
    beat("s1.d7",  1'b0, 1'b1, 8'h92, 3'd7, 8'h80);  tick();
    idle_chk("s1.end");

    // Scenario 2: all-zero block is a lone header; iready high on its cycle
    send("s2", 64'h0);
    beat("s2.hdr", 1'b1, 1'b1, 8'h00, 3'd0, 8'h00);
    chk("s2.iready_on_done", 32'(bus.iready), 32'd1);
    tick();
    idle_chk("s2.end");

    // Scenario 3: fully dense block
    send("s3", BLK_FF);
    beat("s3.hdr", 1'b1, 1'b0, 8'hFF, 3'd0, 8'h00);  tick();
    for (int i = 0; i < 8; i++) begin
      beat($sformatf("s3.d%0d", i), 1'b0, (i == 7), 8'hFF, 3'(i), 8'hFF);
      tick();
    end
    idle_chk("s3.end");

    // Scenario 4: back-to-back blocks with ivalid held high
    bus.ivalid = 1'b1;
    bus.idata  = BLK_A;
    @(negedge clock);
    chk("s4.a.iready", 32'(bus.iready), 32'd1);
    tick();
    bus.idata = BLK_B;
    beat("s4.a.hdr", 1'b1, 1'b0, 8'h08, 3'd0, 8'h00);
    chk("s4.a.hdr.iready", 32'(bus.iready), 32'd0);
    tick();
    beat("s4.a.d3", 1'b0, 1'b1, 8'h08, 3'd3, 8'h33);
    chk("s4.a.d3.iready", 32'(bus.iready), 32'd1);
    tick();
    bus.ivalid = 1'b0;
    beat("s4.b.hdr", 1'b1, 1'b0, 8'h41, 3'd0, 8'h00);  tick();
    beat("s4.b.d0",  1'b0, 1'b0, 8'h41, 3'd0, 8'h5A);  tick();
    beat("s4.b.d6",  1'b0, 1'b1, 8'h41, 3'd6, 8'hC3);  tick();
    idle_chk("s4.end");

    // Scenario 5: oready 1,0,0,1 stalls the first data beat
    send("s5", BLK_S1);
    beat("s5.hdr", 1'b1, 1'b0, 8'h92, 3'd0, 8'h00);
    tick();
    bus.oready = 1'b0;
    beat("s5.d1.stall0", 1'b0, 1'b0, 8'h92, 3'd1, 8'h11);
    chk("s5.stall0.iready", 32'(bus.iready), 32'd0);
    tick();
    bus.ivalid = 1'b1;
    bus.idata  = BLK_JUNK;
    beat("s5.d1.stall1", 1'b0, 1'b0, 8'h92, 3'd1, 8'h11);
    chk("s5.stall1.iready", 32'(bus.iready), 32'd0);
    tick();
    bus.oready = 1'b1;
    bus.ivalid = 1'b0;
    beat("s5.d1.fire", 1'b0, 1'b0, 8'h92, 3'd1, 8'h11);  tick();
    beat("s5.d4",      1'b0, 1'b0, 8'h92, 3'd4, 8'h44);  tick();
    beat("s5.d7",      1'b0, 1'b1, 8'h92, 3'd7, 8'h80);  tick();
    idle_chk("s5.end");

    // Scenario 6: reset during the second data beat discards the block
    send("s6", BLK_S1);
    beat("s6.hdr", 1'b1, 1'b0, 8'h92, 3'd0, 8'h00);  tick();
    beat("s6.d1",  1'b0, 1'b0, 8'h92, 3'd1, 8'h11);  tick();
    beat("s6.d4",  1'b0, 1'b0, 8'h92, 3'd4, 8'h44);
    reset = 1'b1;
    #1;
    chk("s6.iready_in_reset", 32'(bus.iready), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("s6.post.ovalid",   32'(bus.ovalid),   32'd0);
    chk("s6.post.obitmask", 32'(bus.obitmask), 32'd0);
    chk("s6.post.oheader",  32'(bus.oheader),  32'd0);
    chk("s6.post.iready",   32'(bus.iready),   32'd1);
    tick();
    send("s6.new", BLK_R);
    beat("s6.new.hdr", 1'b1, 1'b0, 8'h04, 3'd0, 8'h00);  tick();
    beat("s6.new.d2",  1'b0, 1'b1, 8'h04, 3'd2, 8'h22);  tick();
    idle_chk("s6.end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
